// File: rtl/vector_regfile_lanes_if.sv
// Vector register file port bundle: two read ports, one lane-masked write
// port, clear request and status. The execute stage (master) drives
// addresses and write data; the register file (slave) returns read data,
// busy and wr_err.
interface vector_regfile_lanes_if #(
    parameter int unsigned NREGS  = 16,
    parameter int unsigned LANES  = 4,
    parameter int unsigned LANE_W = 32
) ();
    localparam int unsigned AW = $clog2(NREGS);
    localparam int unsigned VW = LANES * LANE_W;

    logic              clr;
    logic              busy;
    logic              wre;
    logic [LANES-1:0]  wmask;
    logic [AW-1:0]     a1;
    logic [AW-1:0]     a2;
    logic [AW-1:0]     a3;
    logic [VW-1:0]     wd3;
    logic [VW-1:0]     rd1;
    logic [VW-1:0]     rd2;
    logic              wr_err;

    modport master (
        output clr, wre, wmask, a1, a2, a3, wd3,
        input  busy, rd1, rd2, wr_err
    );

    modport slave (
        input  clr, wre, wmask, a1, a2, a3, wd3,
        output busy, rd1, rd2, wr_err
    );
endinterface

// File: rtl/vector_regfile_lanes.sv
// Parametrised vector register file: NREGS registers of LANES x LANE_W bits,
// two registered read ports, one write port with a per-lane mask, and a
// sequential clear engine that zeroes every register after reset or on clr.
// Optional build macro: VRF_BYPASS_EN forwards an accepted same-cycle write
// (merged with the unmasked old lanes) to a matching read port.
module vector_regfile_lanes #(
    parameter int unsigned NREGS  = 16,
    parameter int unsigned LANES  = 4,
    parameter int unsigned LANE_W = 32
) (
    input  logic                    clk,
    input  logic                    rst,
    vector_regfile_lanes_if.slave   bus
);
    localparam int unsigned AW = $clog2(NREGS);
    localparam int unsigned VW = LANES * LANE_W;

    typedef enum logic {
        ST_IDLE  = 1'b0,
        ST_CLEAR = 1'b1
    } state_t;

    state_t          state;
    state_t          state_nxt;
    logic [AW-1:0]   ptr;
    logic [AW-1:0]   ptr_nxt;
    logic            clr_we_c;
    logic            wr_acc_c;

    logic [VW-1:0]   mem [NREGS];
    logic [VW-1:0]   old_c;
    logic [VW-1:0]   merged_c;
    logic [VW-1:0]   rd1_c;
    logic [VW-1:0]   rd2_c;

    // Lane merge: masked lanes from wd3, the rest from the current register.
    always_comb begin
        old_c    = mem[bus.a3];
        merged_c = old_c;
        for (int unsigned l = 0; l < LANES; l++) begin
            if (bus.wmask[l]) begin
                merged_c[l*LANE_W +: LANE_W] = bus.wd3[l*LANE_W +: LANE_W];
            end
        end
    end

    // Next-state logic: clear engine walks ptr; IDLE accepts clr or writes.
    always_comb begin
        state_nxt = state;
        ptr_nxt   = ptr;
        clr_we_c  = 1'b0;
        wr_acc_c  = 1'b0;
        case (state)
            ST_CLEAR: begin
                clr_we_c = 1'b1;
                ptr_nxt  = ptr + AW'(1);
                if (ptr == AW'(NREGS - 1)) begin
                    state_nxt = ST_IDLE;
                end
            end
            ST_IDLE: begin
                if (bus.clr) begin
                    state_nxt = ST_CLEAR;
                    ptr_nxt   = '0;
                end else begin
                    wr_acc_c = bus.wre;
                end
            end
            default: begin
                state_nxt = ST_CLEAR;
                ptr_nxt   = '0;
            end
        endcase
    end

    // State, clear pointer and status flags; wr_err flags a write dropped
    // during the previous cycle (clr+wre in IDLE is not an error).
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state      <= ST_CLEAR;
            ptr        <= '0;
            bus.busy   <= 1'b1;
            bus.wr_err <= 1'b0;
        end else begin
            state      <= state_nxt;
            ptr        <= ptr_nxt;
            bus.busy   <= (state_nxt == ST_CLEAR);
            bus.wr_err <= (state == ST_CLEAR) && bus.wre;
        end
    end

    // Storage: clear engine and accepted writes never coincide.
    always_ff @(posedge clk) begin
        if (clr_we_c) begin
            mem[ptr] <= '0;
        end else if (wr_acc_c) begin
            mem[bus.a3] <= merged_c;
        end
    end

    // Read-port source selection, with optional write forwarding.
    always_comb begin
        rd1_c = mem[bus.a1];
        rd2_c = mem[bus.a2];
`ifdef VRF_BYPASS_EN
        if (wr_acc_c && (bus.a1 == bus.a3)) begin
            rd1_c = merged_c;
        end
        if (wr_acc_c && (bus.a2 == bus.a3)) begin
            rd2_c = merged_c;
        end
`else
        rd1_c = mem[bus.a1];
        rd2_c = mem[bus.a2];
`endif
    end

    // Registered read data, one-cycle latency.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            bus.rd1 <= '0;
            bus.rd2 <= '0;
        end else begin
            bus.rd1 <= rd1_c;
            bus.rd2 <= rd2_c;
        end
    end
endmodule

// File: tb/tb_vector_regfile_lanes.sv
// Testbench for vector_regfile_lanes: a reference model predicts every
// cycle's outputs into a scoreboard queue, a vector table covers masked
// writes, dual reads and collisions, and hand sequences cover clear,
// dropped writes and asynchronous reset.
module tb_vector_regfile_lanes;
    localparam int unsigned NREGS  = 16;
    localparam int unsigned LANES  = 4;
    localparam int unsigned LANE_W = 32;
    localparam int unsigned AW     = 4;
    localparam int unsigned VW     = 128;
`ifdef VRF_BYPASS_EN
    localparam bit BYP = 1'b1;
`else
    localparam bit BYP = 1'b0;
`endif

    logic clk = 1'b0;
    logic rst = 1'b1;

    vector_regfile_lanes_if #(.NREGS(NREGS), .LANES(LANES), .LANE_W(LANE_W)) bus ();

    vector_regfile_lanes #(.NREGS(NREGS), .LANES(LANES), .LANE_W(LANE_W)) dut (
        .clk (clk),
        .rst (rst),
        .bus (bus)
    );

    always #5 clk = ~clk;

    typedef struct {
        logic [VW-1:0] rd1;
        logic [VW-1:0] rd2;
        bit            chk1;
        bit            chk2;
        logic          busy;
        logic          wr_err;
    } exp_t;

    typedef struct {
        logic             wre;
        logic [LANES-1:0] wmask;
        logic [AW-1:0]    a1;
        logic [AW-1:0]    a2;
        logic [AW-1:0]    a3;
        logic [VW-1:0]    wd3;
        logic [VW-1:0]    e1;
        logic [VW-1:0]    e2;
    } vec_t;

    exp_t          sb[$];
    logic [VW-1:0] m_mem [NREGS];
    bit            m_known [NREGS];
    bit            m_busy;
    logic [AW-1:0] m_ptr;
    int            errors = 0;
    int            checks = 0;

    task automatic check(input string name, input logic [VW-1:0] act, input logic [VW-1:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s: got %h expected %h", name, act, exp);
        end
    endtask

    function automatic logic [VW-1:0] merge(input logic [VW-1:0] old, input logic [VW-1:0] d,
                                            input logic [LANES-1:0] m);
        logic [VW-1:0] r;
        r = old;
        for (int l = 0; l < LANES; l++)
            if (m[l]) r[l*LANE_W +: LANE_W] = d[l*LANE_W +: LANE_W];
        return r;
    endfunction

    // One clock: drive inputs, predict, advance past the edge, compare.
    task automatic cycle(input logic c, input logic w, input logic [LANES-1:0] m,
                         input logic [AW-1:0] r1, input logic [AW-1:0] r2,
                         input logic [AW-1:0] w3, input logic [VW-1:0] d);
        exp_t e;
        bit   acc;
        bus.clr = c; bus.wre = w; bus.wmask = m;
        bus.a1 = r1; bus.a2 = r2; bus.a3 = w3; bus.wd3 = d;
        acc    = !m_busy && w && !c;
        e.rd1  = m_mem[r1]; e.chk1 = m_known[r1];
        e.rd2  = m_mem[r2]; e.chk2 = m_known[r2];
        if (BYP && acc && r1 == w3) e.rd1 = merge(m_mem[w3], d, m);
        if (BYP && acc && r2 == w3) e.rd2 = merge(m_mem[w3], d, m);
        e.wr_err = m_busy && w;
        if (m_busy) begin
            m_mem[m_ptr]   = '0;
            m_known[m_ptr] = 1'b1;
            if (m_ptr == AW'(NREGS - 1)) m_busy = 1'b0;
            m_ptr = m_ptr + AW'(1);
        end else if (c) begin
            m_busy = 1'b1;
            m_ptr  = '0;
        end else if (acc) begin
            m_mem[w3]   = merge(m_mem[w3], d, m);
            m_known[w3] = m_known[w3] || (m == '1);
        end
        e.busy = m_busy;
        sb.push_back(e);
        @(posedge clk);
        #1;
        e = sb.pop_front();
        check("busy", VW'(bus.busy), VW'(e.busy));
        check("wr_err", VW'(bus.wr_err), VW'(e.wr_err));
        if (e.chk1) check($sformatf("rd1[a1=%0d]", r1), bus.rd1, e.rd1);
        if (e.chk2) check($sformatf("rd2[a2=%0d]", r2), bus.rd2, e.rd2);
    endtask

    task automatic idle_cycle(input logic [AW-1:0] r1, input logic [AW-1:0] r2);
        cycle(1'b0, 1'b0, '0, r1, r2, '0, '0);
    endtask

    // Asynchronous reset asserted mid-cycle; outputs checked before any edge.
    task automatic apply_reset(input int hold);
        #2;
        rst = 1'b1;
        #1;
        check("rst_busy", VW'(bus.busy), VW'(1'b1));
        check("rst_rd1", bus.rd1, '0);
        check("rst_rd2", bus.rd2, '0);
        check("rst_wr_err", VW'(bus.wr_err), VW'(1'b0));
        m_busy = 1'b1;
        m_ptr  = '0;
        sb.delete();
        repeat (hold) @(posedge clk);
        #1;
        rst = 1'b0;
    endtask

    // Runs idle reads until busy drops; returns the busy-cycle count.
    task automatic wait_clear(output int n);
        n = 0;
        for (int k = 0; k < 64 && bus.busy; k++) begin
            idle_cycle(AW'(k), AW'(k + 7));
            n++;
        end
    endtask

    task automatic read_all_zero();
        for (int i = 0; i < NREGS; i++) begin
            idle_cycle(AW'(i), AW'(NREGS - 1 - i));
            check("zero_rd1", bus.rd1, '0);
            check("zero_rd2", bus.rd2, '0);
        end
    endtask

    initial begin
        #200000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1, "watchdog");
    end

    initial begin
        vec_t tbl [12];
        int   n;
        logic [VW-1:0] vl, vm, va, vb, p5, pa, mg, ff;

        bus.clr = 0; bus.wre = 0; bus.wmask = '0;
        bus.a1 = '0; bus.a2 = '0; bus.a3 = '0; bus.wd3 = '0;
        for (int i = 0; i < NREGS; i++) begin
            m_mem[i]   = '0;
            m_known[i] = 1'b0;
        end

        vl = 128'h44444444_33333333_22222222_11111111;
        vm = 128'h44444444_FFFFFFFF_22222222_FFFFFFFF;
        va = 128'hA5A5A5A5_0000000A_12345678_DEADBEEF;
        vb = 128'h0BADF00D_CAFEBABE_00000009_FEDCBA98;
        p5 = {4{32'h55555555}};
        pa = {4{32'hAAAAAAAA}};
        mg = 128'h55555555_55555555_AAAAAAAA_AAAAAAAA;
        ff = '1;

        // wre, wmask, a1, a2, a3, wd3, expected rd1, expected rd2
        tbl[0]  = '{1'b1, 4'hF, 4'd0, 4'd0, 4'd3, vl, '0, '0};
        tbl[1]  = '{1'b1, 4'h5, 4'd3, 4'd3, 4'd3, ff, BYP ? vm : vl, BYP ? vm : vl};
        tbl[2]  = '{1'b0, 4'h0, 4'd3, 4'd0, 4'd0, '0, vm, '0};
        tbl[3]  = '{1'b1, 4'hF, 4'd3, 4'd3, 4'd5, va, vm, vm};
        tbl[4]  = '{1'b1, 4'hF, 4'd5, 4'd0, 4'd9, vb, va, '0};
        tbl[5]  = '{1'b0, 4'h0, 4'd5, 4'd9, 4'd0, '0, va, vb};
        tbl[6]  = '{1'b0, 4'h0, 4'd9, 4'd9, 4'd0, '0, vb, vb};
        tbl[7]  = '{1'b1, 4'hF, 4'd7, 4'd9, 4'd7, p5, BYP ? p5 : '0, vb};
        tbl[8]  = '{1'b1, 4'h3, 4'd7, 4'd7, 4'd7, pa, BYP ? mg : p5, BYP ? mg : p5};
        tbl[9]  = '{1'b0, 4'h0, 4'd7, 4'd3, 4'd0, '0, mg, vm};
        tbl[10] = '{1'b1, 4'h0, 4'd3, 4'd7, 4'd3, '0, vm, mg};
        tbl[11] = '{1'b0, 4'h0, 4'd3, 4'd3, 4'd0, '0, vm, vm};

        // Power-up reset held two cycles, then busy for exactly NREGS cycles.
        repeat (2) @(posedge clk);
        #1;
        apply_reset(2);
        check("busy_after_release", VW'(bus.busy), VW'(1'b1));
        wait_clear(n);
        check("busy_len_reset", VW'(n), VW'(NREGS));
        read_all_zero();

        // Masked writes, dual-port reads and collisions.
        for (int i = 0; i < 12; i++) begin
            cycle(1'b0, tbl[i].wre, tbl[i].wmask, tbl[i].a1, tbl[i].a2, tbl[i].a3, tbl[i].wd3);
            check($sformatf("tbl%0d_rd1", i), bus.rd1, tbl[i].e1);
            check($sformatf("tbl%0d_rd2", i), bus.rd2, tbl[i].e2);
        end

        // Fill, clear on request, dropped write on the 3rd busy cycle,
        // clr during CLEAR ignored.
        for (int i = 0; i < NREGS; i++)
            cycle(1'b0, 1'b1, 4'hF, '0, '0, AW'(i), {4{32'hC0DE0000 + 32'(i)}});
        cycle(1'b1, 1'b0, '0, 4'd2, 4'd4, '0, '0);
        n = 0;
        for (int k = 0; k < 64 && bus.busy; k++) begin
            if (k == 2)
                cycle(1'b0, 1'b1, 4'hF, 4'd2, 4'd3, 4'd2, {4{32'h12121212}});
            else
                cycle(k == 5, 1'b0, '0, AW'(k), AW'(15 - k), '0, '0);
            if (k == 2) check("wr_err_pulse", VW'(bus.wr_err), VW'(1'b1));
            n++;
        end
        check("busy_len_clr", VW'(n), VW'(NREGS));
        read_all_zero();

        // clr and wre together: clear wins, no error flagged.
        cycle(1'b0, 1'b1, 4'hF, '0, '0, 4'd4, {4{32'h0F0F0F0F}});
        cycle(1'b1, 1'b1, 4'hF, 4'd4, 4'd4, 4'd4, {4{32'h77777777}});
        check("clr_wre_no_err", VW'(bus.wr_err), VW'(1'b0));
        wait_clear(n);
        check("busy_len_clr_wre", VW'(n), VW'(NREGS));
        idle_cycle(4'd4, 4'd4);
        check("clr_wre_reg4", bus.rd1, '0);

        // Asynchronous reset five cycles into a clear restarts it from zero.
        cycle(1'b0, 1'b1, 4'hF, '0, '0, 4'd6, {4{32'h66666666}});
        cycle(1'b1, 1'b0, '0, 4'd6, 4'd6, '0, '0);
        repeat (5) idle_cycle(4'd6, 4'd0);
        apply_reset(2);
        wait_clear(n);
        check("busy_len_midclr", VW'(n), VW'(NREGS));
        read_all_zero();

        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end
endmodule
